// File: rtl/divu8_seq_pkg.sv
// Shared definitions for the sequential 8-bit unsigned divider.
// State encoding, flag layout and divide-by-zero result.
package divu8_seq_pkg;

    localparam int WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FLG_C = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_V = 1;
    localparam int FLG_N = 0;

    localparam logic [WIDTH-1:0] DIV0_Q = 8'hFF;

    function automatic logic [3:0] make_flg(
        input logic [WIDTH-1:0] qv,
        input logic             v
    );
        logic [3:0] f;
        f        = '0;
        f[FLG_Z] = (qv == '0);
        f[FLG_V] = v;
        f[FLG_N] = qv[WIDTH-1];
        return f;
    endfunction

endpackage

// File: rtl/rca8.sv
// 8-bit ripple-carry adder, reused as the divider's trial subtractor.
// Carry chain is explicit so c_8 is the true carry out.
module rca8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c_0,
    output logic [7:0] s,
    output logic       c_8
);

    logic [8:0] c;

    assign c[0] = c_0;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c_8 = c[8];

endmodule

// File: rtl/divu8_seq.sv
// Sequential restoring divider: one quotient bit per RUN cycle.
// Results are registered on entry to DONE and held until the next one.
module divu8_seq
    import divu8_seq_pkg::*;
#(
    parameter int WIDTH = divu8_seq_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic [3:0]       flg
);

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem_sh;
    logic [WIDTH-1:0] quo_sh;
    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic             cout;
    logic             no_borrow;
    logic             accept;
    logic             last;

    assign accept = start && (state != RUN);
    assign last   = (state == RUN) && (cnt == 3'd7);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    assign rem_sh = {rem[WIDTH-2:0], quo[WIDTH-1]};
    assign quo_sh = {quo[WIDTH-2:0], 1'b0};

    rca8 u_sub (
        .a   (rem_sh),
        .b   (~dvs),
        .c_0 (1'b1),
        .s   (trial),
        .c_8 (cout)
    );

    // A bit shifted out of rem means the shifted value exceeds any divisor.
    assign no_borrow = cout | rem[WIDTH-1];
    assign rem_nxt   = no_borrow ? trial : rem_sh;
    assign quo_nxt   = {quo_sh[WIDTH-1:1], no_borrow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = (b == '0) ? DONE : RUN;
            end
            RUN: begin
                if (cnt == 3'd7) state_nxt = DONE;
            end
            DONE: begin
                if (start) state_nxt = (b == '0) ? DONE : RUN;
                else       state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            rem <= '0;
            quo <= '0;
            dvs <= '0;
            q   <= '0;
            r   <= '0;
            flg <= '0;
        end else if (accept) begin
            dvs <= b;
            rem <= '0;
            quo <= a;
            cnt <= '0;
            if (b == '0) begin
                q   <= DIV0_Q;
                r   <= a;
                flg <= make_flg(DIV0_Q, 1'b1);
            end
        end else if (state == RUN) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + 3'd1;
            if (last) begin
                q   <= quo_nxt;
                r   <= rem_nxt;
                flg <= make_flg(quo_nxt, 1'b0);
            end
        end
    end

endmodule

// File: tb/tb_divu8_seq.sv
// Self-checking bench for divu8_seq against an arithmetic reference model.
// Directed scenarios first, then randomized operands.
module tb_divu8_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy;
    logic       done;
    logic [7:0] q;
    logic [7:0] r;
    logic [3:0] flg;

    int vectors = 0;
    int miscompares = 0;

    divu8_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .flg   (flg)
    );

    always #5 clk = ~clk;

    function automatic void model(
        input  logic [7:0] av,
        input  logic [7:0] bv,
        output logic [7:0] eq,
        output logic [7:0] er,
        output logic [3:0] ef
    );
        if (bv == 8'd0) begin
            eq = 8'hFF;
            er = av;
        end else begin
            eq = av / bv;
            er = av % bv;
        end
        ef = {1'b0, (eq == 8'd0), (bv == 8'd0), eq[7]};
    endfunction

    task automatic issue(input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
    endtask

    task automatic wait_done(output int cyc, output int bcnt);
        cyc = 0;
        bcnt = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, done, q, r, flg} !== 22'd0) begin
            miscompares++;
            $display("FAIL reset_state got %h want 0", {busy, done, q, r, flg});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int cyc;
        int bcnt;
        issue(8'd100, 8'd7);
        wait_done(cyc, bcnt);
        vectors++;
        if (cyc !== 8 || bcnt !== 8) begin
            miscompares++;
            $display("FAIL basic_latency got cyc=%0d busy=%0d want 8/8", cyc, bcnt);
        end
        vectors++;
        if ({q, r, flg} !== {8'd14, 8'd2, 4'b0000}) begin
            miscompares++;
            $display("FAIL basic_result got q=%0d r=%0d f=%b want 14 2 0000", q, r, flg);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse got %b want 0", done);
        end
    endtask

    task automatic test_max();
        int cyc;
        int bcnt;
        issue(8'd255, 8'd1);
        wait_done(cyc, bcnt);
        vectors++;
        if ({q, r, flg} !== {8'd255, 8'd0, 4'b0001}) begin
            miscompares++;
            $display("FAIL max_result got q=%0d r=%0d f=%b want 255 0 0001", q, r, flg);
        end
    endtask

    task automatic test_div0();
        int cyc;
        int bcnt;
        issue(8'd5, 8'd0);
        wait_done(cyc, bcnt);
        vectors++;
        if (cyc !== 0 || bcnt !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL div0_latency got cyc=%0d busy=%0d want 0/0", cyc, bcnt);
        end
        vectors++;
        if ({q, r, flg} !== {8'hFF, 8'd5, 4'b0011}) begin
            miscompares++;
            $display("FAIL div0_result got q=%h r=%0d f=%b want ff 5 0011", q, r, flg);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int bcnt;
        issue(8'd3, 8'd10);
        repeat (2) @(negedge clk);
        a = 8'd200;
        b = 8'd200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bcnt);
        vectors++;
        if (cyc !== 5) begin
            miscompares++;
            $display("FAIL ignore_latency got %0d want 5", cyc);
        end
        vectors++;
        if ({q, r, flg} !== {8'd0, 8'd3, 4'b0100}) begin
            miscompares++;
            $display("FAIL ignore_result got q=%0d r=%0d f=%b want 0 3 0100", q, r, flg);
        end
        a = 8'd200;
        b = 8'd200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom);
        wait_done(cyc, bcnt);
        vectors++;
        if (cyc + 1 !== 9) begin
            miscompares++;
            $display("FAIL b2b_period got %0d want 9", cyc + 1);
        end
        vectors++;
        if ({q, r, flg} !== {8'd1, 8'd0, 4'b0000}) begin
            miscompares++;
            $display("FAIL b2b_result got q=%0d r=%0d f=%b want 1 0 0000", q, r, flg);
        end
    endtask

    task automatic test_hold();
        int cyc;
        int bcnt;
        int bad;
        issue(8'd100, 8'd7);
        wait_done(cyc, bcnt);
        issue(8'd255, 8'd1);
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            if ({q, r, flg} !== {8'd14, 8'd2, 4'b0000}) bad++;
            @(negedge clk);
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL hold_in_run got %0d changed cycles want 0", bad);
        end
        wait_done(cyc, bcnt);
        vectors++;
        if ({q, r, flg} !== {8'd255, 8'd0, 4'b0001}) begin
            miscompares++;
            $display("FAIL hold_next got q=%0d r=%0d f=%b want 255 0 0001", q, r, flg);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        int bcnt;
        int seen;
        issue(8'd100, 8'd7);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, q, r, flg} !== 22'd0) begin
            miscompares++;
            $display("FAIL midrun_reset got %h want 0", {busy, done, q, r, flg});
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) seen++;
            @(negedge clk);
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL midrun_no_done got %0d active cycles want 0", seen);
        end
        issue(8'd9, 8'd3);
        wait_done(cyc, bcnt);
        vectors++;
        if ({q, r, flg} !== {8'd3, 8'd0, 4'b0000} || cyc !== 8) begin
            miscompares++;
            $display("FAIL after_reset got q=%0d r=%0d f=%b cyc=%0d want 3 0 0000 8",
                     q, r, flg, cyc);
        end
    endtask

    task automatic test_random();
        int         cyc;
        int         bcnt;
        logic [7:0] av;
        logic [7:0] bv;
        logic [7:0] eq;
        logic [7:0] er;
        logic [3:0] ef;
        for (int i = 0; i < 40; i++) begin
            av = 8'($urandom);
            bv = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            if (i % 7 == 3) bv = 8'd1;
            model(av, bv, eq, er, ef);
            issue(av, bv);
            wait_done(cyc, bcnt);
            vectors++;
            if ({q, r, flg} !== {eq, er, ef} || cyc !== ((bv == 8'd0) ? 0 : 8)) begin
                miscompares++;
                $display("FAIL rand_%0d %0d/%0d got q=%0d r=%0d f=%b cyc=%0d want %0d %0d %b",
                         i, av, bv, q, r, flg, cyc, eq, er, ef);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_div0();
        test_back_to_back();
        test_hold();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
